logic_seq_player: RTL

//  Plays a programmed sequence of output levels, one level per step, each held for a

---
 rtl/logic_seq_player_pkg.sv | 22 ++
 rtl/logic_seq_player_if.sv | 31 +++
 rtl/logic_seq_player_step_ram.sv | 31 +++
 rtl/logic_seq_player.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/logic_seq_player_pkg.sv
// Shared widths, state encoding and step-table payload for the logic sequence player.
package logic_seq_pkg;

    localparam int unsigned STEPS = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 8;
    localparam int unsigned TW    = 24;

    localparam logic [DW-1:0] IDLE_LVL_DEF = 8'h00;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // One step-table entry: hold duration and output level
    typedef struct packed {
        logic [TW-1:0] dur;
        logic [DW-1:0] level;
    } step_t;

endpackage

// File: rtl/logic_seq_player_if.sv
// Config, start/stop control and pattern outputs of the logic sequence player.
interface logic_seq_player_if;
    import logic_seq_pkg::*;

    logic          cfgWe;
    logic [AW-1:0] cfgAddr;
    logic [DW-1:0] cfgLevel;
    logic [TW-1:0] cfgDur;
    logic [AW:0]   stepNo;
    logic          mainTrigger;
    logic          rptEn;
    logic          abort;
    logic [DW-1:0] logicOut;
    logic          active;
    logic [AW-1:0] stepIdx;
    logic          logicEnd;
    logic          trigDrop;

    // Controller / config side
    modport master (
        output cfgWe, cfgAddr, cfgLevel, cfgDur, stepNo, mainTrigger, rptEn, abort,
        input  logicOut, active, stepIdx, logicEnd, trigDrop
    );

    // Player side
    modport slave (
        input  cfgWe, cfgAddr, cfgLevel, cfgDur, stepNo, mainTrigger, rptEn, abort,
        output logicOut, active, stepIdx, logicEnd, trigDrop
    );

endinterface

// File: rtl/logic_seq_player_step_ram.sv
// Step table: STEPS entries of level+duration, one write port, one async read port.
module seq_step_ram
    import logic_seq_pkg::*;
(
    input  logic          io_clk,
    input  logic          we,
    input  logic [AW-1:0] wAddr,
    input  step_t         wData,
    input  logic [AW-1:0] rAddr,
    output step_t         rData_c
);

    step_t mem [STEPS];

    logic wInRange_c;
    logic rInRange_c;

    assign wInRange_c = ({1'b0, wAddr} < (AW+1)'(STEPS));
    assign rInRange_c = ({1'b0, rAddr} < (AW+1)'(STEPS));

    // Table contents are configuration only and are deliberately not reset
    always_ff @(posedge io_clk) begin
        if (we && wInRange_c) begin
            mem[wAddr] <= wData;
        end
    end

    // Combinational read of the entry about to be entered
    assign rData_c = rInRange_c ? mem[rAddr] : '0;

endmodule

// File: rtl/logic_seq_player.sv
// Plays a programmed sequence of output levels, each held for a programmed cycle count.
module logic_seq_player
    import logic_seq_pkg::*;
#(
    parameter logic [DW-1:0] IDLE_LVL = IDLE_LVL_DEF
) (
    input  logic                io_clk,
    input  logic                io_rstN,
    logic_seq_player_if.slave   bus
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_RUN  = RUN;

    logic [0:0]    state,     stateNxt;
    logic [TW-1:0] holdCnt,   holdCntNxt;
    logic [TW-1:0] curDur,    curDurNxt;
    logic [AW:0]   nSteps,    nStepsNxt;
    logic [AW-1:0] stepIdxQ,  stepIdxNxt;
    logic [DW-1:0] logicOutQ, logicOutNxt;
    logic          activeQ,   activeNxt;
    logic          logicEndQ, logicEndNxt;
    logic          trigDropQ, trigDropNxt;

    logic          start_c;
    logic          stepDone_c;
    logic          lastStep_c;
    logic [AW-1:0] rdAddr_c;
    step_t         rdStep_c;
    logic [TW-1:0] entryDur_c;
    step_t         wrStep_c;

    assign wrStep_c = '{dur: bus.cfgDur, level: bus.cfgLevel};

    seq_step_ram u_stepRam (
        .io_clk  (io_clk),
        .we      (bus.cfgWe),
        .wAddr   (bus.cfgAddr),
        .wData   (wrStep_c),
        .rAddr   (rdAddr_c),
        .rData_c (rdStep_c)
    );

    // Read address always points at the step that would be entered next
    assign rdAddr_c   = (state == ST_RUN) ? stepIdxQ + AW'(1) : '0;
    assign start_c    = bus.mainTrigger | bus.rptEn;
    assign entryDur_c = (rdStep_c.dur == '0) ? TW'(1) : rdStep_c.dur;
    assign stepDone_c = (holdCnt == curDur);
    assign lastStep_c = ({1'b0, stepIdxQ} == (nSteps - (AW+1)'(1)));

    // Next-state and next-output logic
    always_comb begin
        stateNxt    = state;
        holdCntNxt  = holdCnt;
        curDurNxt   = curDur;
        nStepsNxt   = nSteps;
        stepIdxNxt  = stepIdxQ;
        logicOutNxt = logicOutQ;
        activeNxt   = activeQ;
        logicEndNxt = 1'b0;
        trigDropNxt = 1'b0;

        if (bus.abort) begin
            stateNxt    = ST_IDLE;
            holdCntNxt  = '0;
            curDurNxt   = '0;
            stepIdxNxt  = '0;
            logicOutNxt = IDLE_LVL;
            activeNxt   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_c) begin
                        if (bus.stepNo != '0) begin
                            stateNxt    = ST_RUN;
                            nStepsNxt   = bus.stepNo;
                            stepIdxNxt  = '0;
                            logicOutNxt = rdStep_c.level;
                            activeNxt   = 1'b1;
                            holdCntNxt  = TW'(1);
                            curDurNxt   = entryDur_c;
                        end else begin
                            // Empty sequence still reports completion
                            logicEndNxt = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    trigDropNxt = start_c;
                    if (stepDone_c) begin
                        if (!lastStep_c) begin
                            stepIdxNxt  = stepIdxQ + AW'(1);
                            logicOutNxt = rdStep_c.level;
                            holdCntNxt  = TW'(1);
                            curDurNxt   = entryDur_c;
                        end else begin
                            stateNxt    = ST_IDLE;
                            stepIdxNxt  = '0;
                            logicOutNxt = IDLE_LVL;
                            activeNxt   = 1'b0;
                            holdCntNxt  = '0;
                            logicEndNxt = 1'b1;
                        end
                    end else begin
                        holdCntNxt = holdCnt + TW'(1);
                    end
                end
                default: begin
                    stateNxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge io_clk or negedge io_rstN) begin
        if (!io_rstN) begin
            state     <= ST_IDLE;
            holdCnt   <= '0;
            curDur    <= '0;
            nSteps    <= '0;
            stepIdxQ  <= '0;
            logicOutQ <= IDLE_LVL;
            activeQ   <= 1'b0;
            logicEndQ <= 1'b0;
            trigDropQ <= 1'b0;
        end else begin
            state     <= stateNxt;
            holdCnt   <= holdCntNxt;
            curDur    <= curDurNxt;
            nSteps    <= nStepsNxt;
            stepIdxQ  <= stepIdxNxt;
            logicOutQ <= logicOutNxt;
            activeQ   <= activeNxt;
            logicEndQ <= logicEndNxt;
            trigDropQ <= trigDropNxt;
        end
    end

    assign bus.logicOut = logicOutQ;
    assign bus.active   = activeQ;
    assign bus.stepIdx  = stepIdxQ;
    assign bus.logicEnd = logicEndQ;
    assign bus.trigDrop = trigDropQ;

endmodule
